// File: rtl/i2c_ext_pkg.sv
// Shared command codes, FSM state encoding and default parameters for the
// extended I2C master.
package i2c_ext_pkg;

  localparam logic [2:0] CMD_START   = 3'b000;
  localparam logic [2:0] CMD_WR      = 3'b001;
  localparam logic [2:0] CMD_RD      = 3'b010;
  localparam logic [2:0] CMD_STOP    = 3'b011;
  localparam logic [2:0] CMD_RESTART = 3'b100;

  localparam int          DVSR_W_DEF      = 16;
  localparam int          TMO_W_DEF       = 20;
  localparam int unsigned STRETCH_TMO_DEF = 32'h000F_FFFF;
  localparam int          SYNC_STAGES_DEF = 2;

  typedef enum logic [3:0] {
    IDLE, START1, START2, HOLD, RESTART,
    DATA1, DATA2, DATA3, DATA4, DATA_END,
    STOP1, STOP2
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Multi-flop synchroniser for one open-drain bus line; resets to the released
// (high) level so a reset never looks like a bus event.
module i2c_line_sync
  import i2c_ext_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_in,
  output logic line_s
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], line_in};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= sync_d;
  end

  assign line_s = sync_q[STAGES-1];

endmodule

// File: rtl/i2c_master_ext.sv
// I2C master with clock stretching, stretch timeout and sticky error flag.
// Define I2C_ARB_LOST_EN to enable multi-master arbitration-loss detection.
module i2c_master_ext
  import i2c_ext_pkg::*;
#(
  parameter int          DVSR_W      = DVSR_W_DEF,
  parameter int          TMO_W       = TMO_W_DEF,
  parameter int unsigned STRETCH_TMO = STRETCH_TMO_DEF,
  parameter int          SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        din,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [2:0]        cmd,
  input  logic              wr_i2c,
  output logic              ready,
  output logic              done_tick,
  output logic              ack,
  output logic [7:0]        dout,
  output logic              err,
  output logic              arb_lost,
  inout  wire               sda,
  inout  wire               scl
);

  state_t            state_q, state_d;
  logic [DVSR_W-1:0] c_q, c_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [8:0]        tx_q, tx_d;
  logic [8:0]        rx_q, rx_d;
  logic [2:0]        cmd_reg_q, cmd_reg_d;
  logic              err_q, err_d;
  logic              sda_reg_q, sda_reg_d;
  logic              scl_reg_q, scl_reg_d;
  logic              sda_s, scl_s;
  logic [DVSR_W-1:0] half;
  logic              qtr_end, half_end, wait_st, tmo_hit, data_rel;
`ifdef I2C_ARB_LOST_EN
  logic              arb_q, arb_d;
`endif

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .reset_n(reset_n), .line_in(sda), .line_s(sda_s)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .reset_n(reset_n), .line_in(scl), .line_s(scl_s)
  );

  assign half     = {dvsr[DVSR_W-2:0], 1'b0};
  assign qtr_end  = (c_q == dvsr);
  assign half_end = (c_q == half);
  assign tmo_hit  = (tmo_q == TMO_W'(STRETCH_TMO));
  assign wait_st  = !scl_s && (state_q == DATA2 || state_q == RESTART || state_q == STOP1);
  // SDA is handed to the slave for read data and for the ACK slot of a write.
  assign data_rel = (cmd_reg_q == CMD_RD && bit_cnt_q < 4'd8) ||
                    (cmd_reg_q == CMD_WR && bit_cnt_q == 4'd8);

  always_comb begin
    state_d   = state_q;
    c_d       = c_q + DVSR_W'(1);
    tmo_d     = '0;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cmd_reg_d = cmd_reg_q;
    err_d     = err_q;
    done_tick = 1'b0;
`ifdef I2C_ARB_LOST_EN
    arb_d     = arb_q;
`endif
    unique case (state_q)
      IDLE: begin
        c_d = '0;
        if (wr_i2c && cmd == CMD_START) begin
          state_d   = START1;
          cmd_reg_d = cmd;
          err_d     = 1'b0;
`ifdef I2C_ARB_LOST_EN
          arb_d     = 1'b0;
`endif
        end
      end
      START1: if (half_end) begin state_d = START2; c_d = '0; end
      START2: if (qtr_end)  begin state_d = HOLD;   c_d = '0; end
      HOLD: begin
        c_d = '0;
        if (wr_i2c) begin
          case (cmd)
            CMD_WR, CMD_RD: begin
              tx_d      = {din, din[0]};
              bit_cnt_d = '0;
              cmd_reg_d = cmd;
              state_d   = DATA1;
            end
            CMD_STOP: begin
              cmd_reg_d = cmd;
              state_d   = STOP1;
            end
            CMD_START, CMD_RESTART: begin
              cmd_reg_d = cmd;
              state_d   = RESTART;
            end
            default: ;
          endcase
        end
      end
      DATA1: if (qtr_end) begin state_d = DATA2; c_d = '0; end
      DATA2: begin
        if (scl_s && qtr_end) begin
          c_d     = '0;
          rx_d    = {rx_q[7:0], sda_s};
          state_d = DATA3;
`ifdef I2C_ARB_LOST_EN
          if (cmd_reg_q == CMD_WR && bit_cnt_q < 4'd8 && tx_q[8] && !sda_s) begin
            arb_d   = 1'b1;
            state_d = IDLE;
          end
`endif
        end
      end
      DATA3: if (qtr_end) begin state_d = DATA4; c_d = '0; end
      DATA4: begin
        if (qtr_end) begin
          c_d = '0;
          if (bit_cnt_q == 4'd8) begin
            done_tick = 1'b1;
            state_d   = DATA_END;
          end else begin
            tx_d      = {tx_q[7:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
            state_d   = DATA1;
          end
        end
      end
      DATA_END: if (qtr_end) begin state_d = HOLD; c_d = '0; end
      RESTART:  if (scl_s && half_end) begin state_d = START1; c_d = '0; end
      STOP1:    if (scl_s && half_end) begin state_d = STOP2;  c_d = '0; end
      STOP2:    if (half_end) begin state_d = IDLE; c_d = '0; end
      default:  state_d = IDLE;
    endcase
    // Phase counter parks at 0 while a slave stretches SCL; a stuck bus aborts.
    if (wait_st) begin
      c_d = '0;
      if (tmo_hit) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  always_comb begin
    sda_reg_d = 1'b1;
    scl_reg_d = 1'b1;
    unique case (state_q)
      IDLE, RESTART, STOP2: begin sda_reg_d = 1'b1; scl_reg_d = 1'b1; end
      START1, STOP1:        begin sda_reg_d = 1'b0; scl_reg_d = 1'b1; end
      START2, HOLD, DATA_END: begin sda_reg_d = 1'b0; scl_reg_d = 1'b0; end
      DATA1, DATA4:         begin sda_reg_d = data_rel | tx_q[8]; scl_reg_d = 1'b0; end
      DATA2, DATA3:         begin sda_reg_d = data_rel | tx_q[8]; scl_reg_d = 1'b1; end
      default:              begin sda_reg_d = 1'b1; scl_reg_d = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      c_q       <= '0;
      tmo_q     <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      cmd_reg_q <= CMD_START;
      err_q     <= 1'b0;
      sda_reg_q <= 1'b1;
      scl_reg_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      tmo_q     <= tmo_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cmd_reg_q <= cmd_reg_d;
      err_q     <= err_d;
      sda_reg_q <= sda_reg_d;
      scl_reg_q <= scl_reg_d;
    end
  end

`ifdef I2C_ARB_LOST_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) arb_q <= 1'b0;
    else          arb_q <= arb_d;
  end
  assign arb_lost = arb_q;
`else
  assign arb_lost = 1'b0;
`endif

  assign sda   = sda_reg_q ? 1'bz : 1'b0;
  assign scl   = scl_reg_q ? 1'bz : 1'b0;
  assign ready = (state_q == IDLE) || (state_q == HOLD);
  assign dout  = rx_q[8:1];
  assign ack   = rx_q[0];
  assign err   = err_q;

endmodule

// File: doc/i2c_master_ext.md
# i2c_master_ext

Parametrised successor to the team's basic I2C master, driven by the same software driver command set. It adds the following behaviour:
- slave clock stretching, with a configurable timeout;
- synchronised read-back of both bus lines;
- a sticky error flag;
- optional multi-master arbitration-loss detection.

It sits between the processor register interface and the FPGA open-drain SDA/SCL pads.

## Interface
- DVSR_W, 16: width of the quarter-period divisor.
- TMO_W, 20: width of the stretch-timeout counter.
- STRETCH_TMO, 20'hFFFFF: maximum number of cycles the SCL line may stay low while the master is releasing it.
- SYNC_STAGES, 2: flop stages on the SDA/SCL input synchronisers (minimum 2).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- din  in  8  byte to transmit; din[0] is also the master ACK/NACK bit on reads.
- dvsr  in  DVSR_W  quarter SCL period, in clk cycles minus 1.
- cmd  in  3  command: START=000, WR=001, RD=010, STOP=011, RESTART=100.
- wr_i2c  in  1  command strobe.
- ready  out  1  1 in IDLE and HOLD.
- done_tick  out  1  one-cycle pulse when a 9-bit byte completes.
- ack  out  1  9th bit sampled (0 = ACK).
- dout  out  8  received byte.
- err  out  1  sticky stretch-timeout flag.
- arb_lost  out  1  sticky arbitration-loss flag.
- sda  inout  1  open-drain data line.
- scl  inout  1  open-drain clock line.

## Operation
**Line drive and sampling**
- Lines are driven only low or Z. The internal sda_reg and scl_reg both reset to 1, i.e. the lines are released.
- Pad inputs pass through SYNC_STAGES flops to give sda_s and scl_s. All sampling uses these synchronised values.

**State machine**
- States: IDLE, START1, START2, HOLD, RESTART, DATA1, DATA2, DATA3, DATA4, DATA_END, STOP1, STOP2.
- IDLE: only wr_i2c with cmd=START is accepted.
  - On acceptance, err and arb_lost are cleared and the FSM goes to START1.
  - Any other command is ignored.
- START1: SDA low, SCL released. Lasts a half period, then START2.
- START2: SDA low, SCL low. Lasts a quarter period, then HOLD.
- HOLD: both lines low. On wr_i2c:
  - WR or RD: load tx = {din, din[0]}, clear bit_cnt, go to DATA1.
  - STOP: go to STOP1.
  - START or RESTART: go to RESTART.
  - Codes 101 to 111: ignored, FSM stays in HOLD.
- The command is latched into cmd_reg when accepted.

**Data phase** (each bit runs DATA1 → DATA2 → DATA3 → DATA4)
- DATA1 (SCL low): drive tx[8].
- DATA2 (SCL released): stretch-wait, then a quarter period.
  - At the end of DATA2: rx = {rx[7:0], sda_s}.
- DATA3 (SCL released): a quarter period.
- DATA4 (SCL low): a quarter period.
  - If bit_cnt = 8: pulse done_tick and go to DATA_END.
  - Otherwise: shift tx left, increment bit_cnt, go to DATA1.
- SDA is released (Z) in two cases:
  - RD with bit_cnt < 8;
  - WR with bit_cnt = 8, to receive the ACK.
- DATA_END: both lines low for a quarter period, then HOLD.
- dout = rx[8:1]; ack = rx[0].

**Restart and stop**
- RESTART: both lines released. Stretch-wait, then a half period, then START1.
- STOP1: SDA low, SCL released. Stretch-wait, then a half period, then STOP2.
- STOP2: both lines released for a half period, then IDLE.

**Clock stretching**
- A stretch-wait occurs in DATA2, RESTART and STOP1 while scl_s = 0.
- During a stretch-wait the phase counter is held at 0 and the timeout counter increments.
- When scl_s is seen as 1, the timeout counter is cleared and the phase counter starts.
- If the timeout counter reaches STRETCH_TMO:
  - set err;
  - release both lines;
  - go to IDLE;
  - done_tick does not pulse.

## Timing
- Quarter phase = dvsr+1 cycles (the counter runs 0..dvsr).
- Half phase = 2·dvsr+1 cycles (the counter runs 0..2·dvsr; half is formed as dvsr<<1 at DVSR_W bits, overflow discarded).
- Unstretched bit period = 4·(dvsr+1) + SYNC_STAGES + 1 cycles, because of the SCL read-back latency.
- A command is accepted on the clk edge where wr_i2c=1 and ready=1. ready drops on the next cycle.
- done_tick is asserted on the final cycle of DATA4, when rx already holds all 9 bits.
- Reset values:
  - ready = 1 (IDLE);
  - done_tick, err, arb_lost, ack = 0;
  - dout = 0x00;
  - sda and scl = Z.
- Asynchronous reset mid-transfer releases both lines immediately (the registered drivers clear without waiting for a clk edge) and returns the FSM to IDLE.
- wr_i2c while ready=0 is ignored and not queued.

## Configuration
Macro `I2C_ARB_LOST_EN`:
- **Defined:** in DATA2 of a WR with bit_cnt < 8, if tx[8] = 1 and sda_s = 0 at the sample point:
  - set arb_lost;
  - release both lines on the next cycle;
  - go to IDLE;
  - done_tick does not pulse.
- **Undefined:** no arbitration check. arb_lost is tied to 0.

## Structure
- Package i2c_ext_pkg holds:
  - the cmd code localparams;
  - the state_t enum;
  - default parameter values.
- Sub-module i2c_line_sync: SYNC_STAGES-deep synchroniser. It is instantiated once per line and resets to 1.
- The top level contains the FSM, the phase counter, the timeout counter, the shift registers and the pad drivers.

## Test plan
1. Reset then START, WR din=0xA4, slave ACKs, STOP, with dvsr=4:
   - SCL shows 9 pulses; the SDA bit stream is 1,0,1,0,0,1,0,0;
   - done_tick pulses once; ack = 0;
   - bit period = 23 cycles.
2. RD with slave byte 0x5A and din[0]=1:
   - dout = 0x5A after done_tick;
   - master releases SDA on the 9th bit (NACK).
3. Slave holds SCL low for 100 cycles in DATA2, with STRETCH_TMO=1000:
   - the bit completes 100 cycles late;
   - err stays 0.
4. Slave holds SCL low indefinitely, with STRETCH_TMO=50:
   - err = 1 after 50 cycles;
   - lines released, FSM in IDLE, ready = 1, no done_tick.
5. reset_n asserted mid-byte: SDA and SCL go to Z with no clk edge needed, and ready = 1.
6. With `I2C_ARB_LOST_EN` defined, WR 0xFF with SDA forced low on bit 2:
   - arb_lost = 1;
   - FSM in IDLE;
   - a following START clears arb_lost.
